// File: rtl/sga_render_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sga_render_pkg
// Description : Shared types and constants for the Snake Game Arcade render
//               engine: FSM state encoding, frame-buffer pixel codes and the
//               frame-buffer depth helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package sga_render_pkg;

    localparam int SGA_COORD_W = 3;
    localparam int SGA_SIZE_W  = 4;

    // Encoding is visible on db_state, so the values are fixed explicitly.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_APPLE = 3'd5
    } render_state_t;

    localparam logic [1:0] PIX_EMPTY = 2'b00;
    localparam logic [1:0] PIX_BODY  = 2'b01;
    localparam logic [1:0] PIX_HEAD  = 2'b10;
    localparam logic [1:0] PIX_APPLE = 2'b11;

    // Number of pixels on a square board of 2^coord_w per side.
    function automatic int fb_depth(input int coord_w);
        return 1 << (2 * coord_w);
    endfunction

    localparam int FB_DEPTH = fb_depth(SGA_COORD_W);

endpackage
`default_nettype wire

// File: rtl/sga_fb_clear_counter.sv
`default_nettype none
// ============================================================================
// Module      : sga_fb_clear_counter
// Description : Frame-buffer clear sweep counter. Walks every pixel address
//               once and flags the final address so the FSM knows the sweep
//               is done.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               i_restart - force the sweep back to address 0
//               i_en      - advance one address
//               o_addr    - current sweep address
//               o_last    - current address is the last pixel
// Revision    : 1.0 - initial release
// ============================================================================
module sga_fb_clear_counter
    import sga_render_pkg::*;
#(
    parameter int COORD_W = SGA_COORD_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_restart,
    input  logic                   i_en,
    output logic [2*COORD_W-1:0]   o_addr,
    output logic                   o_last
);

    localparam int ADDR_W = 2 * COORD_W;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(fb_depth(COORD_W) - 1);

    logic [ADDR_W-1:0] r_addr;

    // Restart wins over enable so a new clear always begins at pixel 0.
    // After the last pixel the counter wraps to 0, ready for the next frame.
    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_addr <= '0;
        end else if (i_en) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_addr == c_last_addr);

endmodule
`default_nettype wire

// File: rtl/sga_render_engine.sv
`default_nettype none
// ============================================================================
// Module      : sga_render_engine
// Description : Render handshake responder. render_clr clears the frame
//               buffer and latches the snake length; each render_count step
//               draws one body segment (read from the 1-cycle-latency body
//               RAM) and finally the apple, then raises render_finish.
// Ports       : clock, reset          - clock, sync active-high reset
//               render_clr            - clear frame / latch snake_size
//               render_count          - draw next object (ignored when busy)
//               snake_size, apple_pos - frame inputs
//               seg_rd_addr/seg_rd_data - body RAM read port
//               fb_we/fb_addr/fb_data - frame buffer write port
//               busy, render_finish, db_state - status
// Options     : SGA_RENDER_HEAD_MARK_EN - segment 0 drawn with the head code
// Revision    : 1.0 - initial release
// ============================================================================
module sga_render_engine
    import sga_render_pkg::*;
#(
    parameter int COORD_W = SGA_COORD_W,
    parameter int SIZE_W  = SGA_SIZE_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   render_clr,
    input  logic                   render_count,
    input  logic [SIZE_W-1:0]      snake_size,
    input  logic [2*COORD_W-1:0]   apple_pos,
    output logic [SIZE_W-1:0]      seg_rd_addr,
    input  logic [2*COORD_W-1:0]   seg_rd_data,
    output logic                   fb_we,
    output logic [2*COORD_W-1:0]   fb_addr,
    output logic [1:0]             fb_data,
    output logic                   busy,
    output logic                   render_finish,
    output logic [2:0]             db_state
);

    localparam int PIX_W = 2 * COORD_W;

    render_state_t      r_state,      w_state_n;
    // One extra bit so idx can equal a full-length snake without wrapping.
    logic [SIZE_W:0]    r_idx,        w_idx_n;
    logic [SIZE_W-1:0]  r_size_q,     w_size_n;
    logic               r_apple_done, w_apple_done_n;
    logic               r_finish,     w_finish_n;

    // Frame-buffer address/data hold their last written values when idle.
    logic [PIX_W-1:0]   r_fb_addr_hold;
    logic [1:0]         r_fb_data_hold;

    logic               w_fb_we;
    logic [PIX_W-1:0]   w_fb_addr;
    logic [1:0]         w_fb_data;
    logic [1:0]         w_seg_code;

    logic [PIX_W-1:0]   w_clr_addr;
    logic               w_clr_last;

    sga_fb_clear_counter #(
        .COORD_W   (COORD_W)
    ) u_clear_counter (
        .clk       (clock),
        .rst       (reset),
        .i_restart (render_clr),
        .i_en      (r_state == ST_CLEAR),
        .o_addr    (w_clr_addr),
        .o_last    (w_clr_last)
    );

`ifdef SGA_RENDER_HEAD_MARK_EN
    assign w_seg_code = (r_idx == '0) ? PIX_HEAD : PIX_BODY;
`else
    assign w_seg_code = PIX_BODY;
`endif

    always_comb begin
        w_state_n      = r_state;
        w_idx_n        = r_idx;
        w_size_n       = r_size_q;
        w_apple_done_n = r_apple_done;
        w_fb_we        = 1'b0;
        w_fb_addr      = r_fb_addr_hold;
        w_fb_data      = r_fb_data_hold;

        unique case (r_state)
            ST_IDLE: begin
                if (render_count) begin
                    if (r_idx < {1'b0, r_size_q}) begin
                        w_state_n = ST_READ;
                    end else if (!r_apple_done) begin
                        w_state_n = ST_APPLE;
                    end
                end
            end
            ST_CLEAR: begin
                w_fb_we   = 1'b1;
                w_fb_addr = w_clr_addr;
                w_fb_data = PIX_EMPTY;
                if (w_clr_last) begin
                    w_state_n = ST_IDLE;
                end
            end
            // seg_rd_addr follows idx, so the RAM sees a stable address in
            // READ and WAIT and the data is valid throughout WRITE.
            ST_READ:  w_state_n = ST_WAIT;
            ST_WAIT:  w_state_n = ST_WRITE;
            ST_WRITE: begin
                w_fb_we   = 1'b1;
                w_fb_addr = seg_rd_data;
                w_fb_data = w_seg_code;
                w_idx_n   = r_idx + 1'b1;
                w_state_n = ST_IDLE;
            end
            ST_APPLE: begin
                w_fb_we        = 1'b1;
                w_fb_addr      = apple_pos;
                w_fb_data      = PIX_APPLE;
                w_apple_done_n = 1'b1;
                w_state_n      = ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase

        // A new frame overrides whatever step is in flight. The write of the
        // current cycle (if any) still completes.
        if (render_clr) begin
            w_state_n      = ST_CLEAR;
            w_idx_n        = '0;
            w_apple_done_n = 1'b0;
            w_size_n       = snake_size;
        end

        // Computed from next-cycle values so the registered flag lines up
        // with the state it describes.
        w_finish_n = (w_state_n == ST_IDLE) && (w_idx_n == {1'b0, w_size_n})
                     && w_apple_done_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_size_q       <= '0;
            r_apple_done   <= 1'b0;
            r_finish       <= 1'b0;
            r_fb_addr_hold <= '0;
            r_fb_data_hold <= PIX_EMPTY;
        end else begin
            r_state        <= w_state_n;
            r_idx          <= w_idx_n;
            r_size_q       <= w_size_n;
            r_apple_done   <= w_apple_done_n;
            r_finish       <= w_finish_n;
            r_fb_addr_hold <= w_fb_addr;
            r_fb_data_hold <= w_fb_data;
        end
    end

    assign seg_rd_addr   = r_idx[SIZE_W-1:0];
    assign fb_we         = w_fb_we;
    assign fb_addr       = w_fb_addr;
    assign fb_data       = w_fb_data;
    assign busy          = (r_state != ST_IDLE);
    assign render_finish = r_finish;
    assign db_state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sga_render_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sga_render_engine
// Description : Self-checking bench for sga_render_engine. A sync-read body
//               RAM model feeds the DUT; every frame-buffer write is logged
//               with its cycle number and compared against the expected
//               draw order (segments 0..size-1, then the apple).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sga_render_engine;

    localparam int COORD_W = 3;
    localparam int SIZE_W  = 4;
    localparam int PIX_W   = 2 * COORD_W;

`ifdef SGA_RENDER_HEAD_MARK_EN
    localparam logic [1:0] HEAD_CODE = 2'b10;
`else
    localparam logic [1:0] HEAD_CODE = 2'b01;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               render_clr;
    logic               render_count;
    logic [SIZE_W-1:0]  snake_size;
    logic [PIX_W-1:0]   apple_pos;
    logic [SIZE_W-1:0]  seg_rd_addr;
    logic [PIX_W-1:0]   seg_rd_data;
    logic               fb_we;
    logic [PIX_W-1:0]   fb_addr;
    logic [1:0]         fb_data;
    logic               busy;
    logic               render_finish;
    logic [2:0]         db_state;

    always #5 clock = ~clock;

    sga_render_engine #(
        .COORD_W      (COORD_W),
        .SIZE_W       (SIZE_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .render_clr   (render_clr),
        .render_count (render_count),
        .snake_size   (snake_size),
        .apple_pos    (apple_pos),
        .seg_rd_addr  (seg_rd_addr),
        .seg_rd_data  (seg_rd_data),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .busy         (busy),
        .render_finish(render_finish),
        .db_state     (db_state)
    );

    // Body RAM: one cycle read latency.
    logic [PIX_W-1:0] ram [16];
    always @(posedge clock) seg_rd_data <= ram[seg_rd_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [PIX_W-1:0] addr;
        logic [1:0]       data;
    } wr_t;

    wr_t log_q[$];
    wr_t exp_q[$];

    always @(negedge clock) begin
        if (fb_we === 1'b1) log_q.push_back('{cyc, fb_addr, fb_data});
    end

    int errors = 0;
    int checks = 0;

    // Reference draw order: segments in index order, apple last.
    task automatic build_expect(input int size, input logic [PIX_W-1:0] apple);
        exp_q.delete();
        for (int i = 0; i < size; i++)
            exp_q.push_back('{0, ram[i], (i == 0) ? HEAD_CODE : 2'b01});
        exp_q.push_back('{0, apple, 2'b11});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 16; i++) ram[i] = PIX_W'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got=%b exp=0", fb_we); end
        checks++; if (fb_addr !== '0 || fb_data !== 2'b00) begin errors++; $display("FAIL reset_fb got=%h/%b exp=00/00", fb_addr, fb_data); end
        checks++; if (seg_rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr got=%h exp=0", seg_rd_addr); end
        checks++; if (render_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", render_finish); end
        checks++; if (db_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", db_state); end
    endtask

    // A render_count with no prior render_clr sees size 0 and draws the apple.
    task automatic test_pre_clr();
        int base, start;
        bit ok;
        apple_pos = 6'h2D;
        base = log_q.size();
        start = cyc;
        render_count = 1'b1; tick(); render_count = 1'b0;
        wait_idle(20, ok);
        checks++; if (!ok) begin errors++; $display("FAIL preclr_timeout busy=%b exp=0", busy); end
        checks++;
        if (log_q.size() - base != 1) begin
            errors++; $display("FAIL preclr_count got=%0d exp=1", log_q.size() - base);
        end else if (log_q[base].addr !== 6'h2D || log_q[base].data !== 2'b11 || log_q[base].cyc - start != 1) begin
            errors++; $display("FAIL preclr_apple got=%h/%b lat=%0d exp=2d/11 lat=1",
                               log_q[base].addr, log_q[base].data, log_q[base].cyc - start);
        end
        checks++; if (render_finish !== 1'b1) begin errors++; $display("FAIL preclr_finish got=%b exp=1", render_finish); end
    endtask

    task automatic test_clear(input int size);
        int base, nbad;
        bit ok;
        base = log_q.size();
        snake_size = SIZE_W'(size);
        render_clr = 1'b1; tick(); render_clr = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy got=%b exp=1", busy); end
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clear_timeout busy=%b exp=0", busy); end
        checks++;
        if (log_q.size() - base != 64) begin
            errors++; $display("FAIL clear_count got=%0d exp=64", log_q.size() - base);
        end else begin
            nbad = 0;
            for (int i = 0; i < 64; i++)
                if (log_q[base+i].addr != PIX_W'(i) || log_q[base+i].data !== 2'b00 ||
                    log_q[base+i].cyc != log_q[base].cyc + i) nbad++;
            checks++; if (nbad != 0) begin errors++; $display("FAIL clear_content bad=%0d exp=0", nbad); end
            checks++; if (cyc != log_q[base+63].cyc + 1) begin errors++; $display("FAIL clear_busy_drop got=%0d exp=%0d", cyc, log_q[base+63].cyc + 1); end
        end
        checks++; if (render_finish !== 1'b0) begin errors++; $display("FAIL clear_finish got=%b exp=0", render_finish); end
    endtask

    // One pulse per object, waiting for idle between pulses.
    task automatic test_steps(input int size);
        int base, start, lat;
        bit ok;
        build_expect(size, apple_pos);
        for (int k = 0; k < exp_q.size(); k++) begin
            base = log_q.size();
            start = cyc;
            lat = (k < size) ? 3 : 1;
            render_count = 1'b1; tick(); render_count = 1'b0;
            wait_idle(20, ok);
            checks++; if (!ok) begin errors++; $display("FAIL step%0d_timeout busy=%b exp=0", k, busy); end
            checks++;
            if (log_q.size() - base != 1) begin
                errors++; $display("FAIL step%0d_count got=%0d exp=1", k, log_q.size() - base);
            end else if (log_q[base].addr !== exp_q[k].addr || log_q[base].data !== exp_q[k].data ||
                         log_q[base].cyc - start != lat) begin
                errors++; $display("FAIL step%0d_write got=%h/%b lat=%0d exp=%h/%b lat=%0d", k,
                                   log_q[base].addr, log_q[base].data, log_q[base].cyc - start,
                                   exp_q[k].addr, exp_q[k].data, lat);
            end
            checks++;
            if (render_finish !== ((k == exp_q.size() - 1) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL step%0d_finish got=%b exp=%b", k, render_finish, k == exp_q.size() - 1);
            end
        end
        base = log_q.size();
        render_count = 1'b1; tick(); render_count = 1'b0;
        repeat (8) tick();
        checks++; if (log_q.size() != base || busy !== 1'b0) begin errors++; $display("FAIL extra_pulse writes=%0d busy=%b exp=0/0", log_q.size() - base, busy); end
        checks++; if (render_finish !== 1'b1) begin errors++; $display("FAIL extra_finish got=%b exp=1", render_finish); end
    endtask

    task automatic check_frame(input string name, input int base);
        int nbad;
        checks++;
        if (log_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL %s_count got=%0d exp=%0d", name, log_q.size() - base, exp_q.size());
        end else begin
            nbad = 0;
            for (int i = 0; i < exp_q.size(); i++)
                if (log_q[base+i].addr !== exp_q[i].addr || log_q[base+i].data !== exp_q[i].data) nbad++;
            checks++; if (nbad != 0) begin errors++; $display("FAIL %s_content bad=%0d exp=0", name, nbad); end
        end
        checks++; if (render_finish !== 1'b1) begin errors++; $display("FAIL %s_finish got=%b exp=1", name, render_finish); end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        test_clear(3);
        build_expect(3, apple_pos);
        base = log_q.size();
        render_count = 1'b1;
        repeat (20) tick();
        render_count = 1'b0;
        wait_idle(20, ok);
        tick();
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout busy=%b exp=0", busy); end
        check_frame("b2b", base);
    endtask

    // render_clr mid-sweep restarts from 0 and re-samples snake_size (5 -> 0).
    task automatic test_clr_restart();
        int base, nbad, e, start;
        bit ok;
        base = log_q.size();
        snake_size = 4'd5;
        render_clr = 1'b1; tick(); render_clr = 1'b0;
        snake_size = 4'd0;
        repeat (30) tick();
        checks++; if (fb_we !== 1'b1 || fb_addr !== 6'd30) begin errors++; $display("FAIL restart_at30 got=%b/%0d exp=1/30", fb_we, fb_addr); end
        render_clr = 1'b1; tick(); render_clr = 1'b0;
        wait_idle(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL restart_timeout busy=%b exp=0", busy); end
        checks++;
        if (log_q.size() - base != 95) begin
            errors++; $display("FAIL restart_count got=%0d exp=95", log_q.size() - base);
        end else begin
            nbad = 0;
            for (int i = 0; i < 95; i++) begin
                e = (i < 31) ? i : i - 31;
                if (log_q[base+i].addr != e[PIX_W-1:0] || log_q[base+i].data !== 2'b00) nbad++;
            end
            checks++; if (nbad != 0) begin errors++; $display("FAIL restart_content bad=%0d exp=0", nbad); end
        end
        apple_pos = 6'h11;
        base = log_q.size();
        start = cyc;
        render_count = 1'b1; tick(); render_count = 1'b0;
        wait_idle(20, ok);
        checks++;
        if (log_q.size() - base != 1) begin
            errors++; $display("FAIL size0_count got=%0d exp=1", log_q.size() - base);
        end else if (log_q[base].addr !== 6'h11 || log_q[base].data !== 2'b11 || log_q[base].cyc - start != 1) begin
            errors++; $display("FAIL size0_apple got=%h/%b lat=%0d exp=11/11 lat=1",
                               log_q[base].addr, log_q[base].data, log_q[base].cyc - start);
        end
        checks++; if (render_finish !== 1'b1) begin errors++; $display("FAIL size0_finish got=%b exp=1", render_finish); end
    endtask

    task automatic test_reset_mid_write();
        fill_ram();
        test_clear(2);
        render_count = 1'b1; tick(); render_count = 1'b0;
        tick();
        tick();
        checks++; if (fb_we !== 1'b1 || fb_data !== HEAD_CODE) begin errors++; $display("FAIL midwr_write got=%b/%b exp=1/%b", fb_we, fb_data, HEAD_CODE); end
        reset = 1'b1;
        tick();
        checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL midwr_fb_we got=%b exp=0", fb_we); end
        checks++; if (busy !== 1'b0 || db_state !== 3'd0 || render_finish !== 1'b0) begin
            errors++; $display("FAIL midwr_state got=%b/%0d/%b exp=0/0/0", busy, db_state, render_finish);
        end
        reset = 1'b0;
    endtask

    // Random lengths, contents and pulse patterns; size 15 forced once.
    task automatic test_random();
        int size, base;
        for (int it = 0; it < 6; it++) begin
            size = (it == 0) ? 15 : int'($urandom_range(0, 15));
            fill_ram();
            apple_pos = PIX_W'($urandom);
            test_clear(size);
            build_expect(size, apple_pos);
            base = log_q.size();
            for (int t = 0; t < 400 && render_finish !== 1'b1; t++) begin
                render_count = 1'($urandom_range(0, 1));
                tick();
            end
            render_count = 1'b0;
            repeat (4) tick();
            check_frame($sformatf("rand%0d", it), base);
        end
    endtask

    initial begin
        reset        = 1'b1;
        render_clr   = 1'b0;
        render_count = 1'b0;
        snake_size   = '0;
        apple_pos    = '0;
        for (int i = 0; i < 16; i++) ram[i] = '0;

        test_reset();
        test_pre_clr();

        ram[0] = 6'h1B; ram[1] = 6'h1A; ram[2] = 6'h19;
        apple_pos = 6'h2D;
        test_clear(3);
        test_steps(3);

        test_back_to_back();
        test_clr_restart();
        test_reset_mid_write();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout cyc=%0d exp=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
